// File: rtl/seg_pkg.sv
// Shared types and sizing constants for the Segway balance sequencer.
package seg_pkg;

  typedef enum logic [2:0] {
    OFF,
    IDLE,
    SETTLE,
    STEER,
    FAULT
  } bal_seq_st_t;

  localparam int SETTLE_W_FAST = 15;
  localparam int SETTLE_W_FULL = 26;

  function automatic int settle_w(input bit fast_sim);
    return fast_sim ? SETTLE_W_FAST : SETTLE_W_FULL;
  endfunction

endpackage

// File: rtl/balance_seq_if.sv
// Signal bundle between the auth/load-cell side (master) and balance_seq (slave).
interface balance_seq_if;

  logic        pwr_req;
  logic        ld_vld;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        vld;
  logic        too_fast;
  logic        pwr_up;
  logic        en_steer;
  logic        rider_off;
  logic        fault;

  modport master (
    output pwr_req, ld_vld, lft_ld, rght_ld, vld, too_fast,
    input  pwr_up, en_steer, rider_off, fault
  );

  modport slave (
    input  pwr_req, ld_vld, lft_ld, rght_ld, vld, too_fast,
    output pwr_up, en_steer, rider_off, fault
  );

endinterface

// File: rtl/balance_seq_settle_tmr.sv
// Settle timer: free-running up-counter while enabled, synchronous clear, full = all ones.
module settle_tmr #(
  parameter int W = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic full
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + W'(1);
  end

  assign full = &cnt_q;

endmodule

// File: rtl/balance_seq.sv
// Power-up / rider-mount sequencer for the balance controller.
// Optional too_fast fault latch enabled by defining BAL_SEQ_FAULT_EN.
module balance_seq
  import seg_pkg::*;
#(
  parameter bit          fast_sim     = 1'b1,
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040
) (
  input  logic          clk,
  input  logic          rst_n,
  balance_seq_if.slave  bus
);

  localparam int          TMR_W   = settle_w(fast_sim);
  localparam logic [12:0] ON_THR  = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] OFF_THR = {1'b0, MIN_RIDER_WT - WT_HYST};

  bal_seq_st_t state_q, state_d;
  logic [11:0] lft_q, rght_q;
  logic        rider_on_q, rider_on_d;
  logic        pwr_up_q, en_steer_q, rider_off_q, fault_q;

  logic [12:0] sum;
  logic [11:0] diff;
  logic        balanced, step_off;
  logic        tmr_full;
  logic        tf_trip;

  // Load math runs continuously on the last captured cell readings.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum      = {1'b0, lft_q} + {1'b0, rght_q};
    diff     = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
    balanced = ({1'b0, diff} < (sum >> 2));
    step_off = ({1'b0, diff} > (sum - (sum >> 4)));

    rider_on_d = rider_on_q;
    if (sum > ON_THR)       rider_on_d = 1'b1;
    else if (sum < OFF_THR) rider_on_d = 1'b0;
  end

  settle_tmr #(.W(TMR_W)) u_settle_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != SETTLE),
    .en    (state_q == SETTLE),
    .full  (tmr_full)
  );

`ifdef BAL_SEQ_FAULT_EN
  logic [1:0] tf_cnt_q, tf_cnt_d;

  // Counts consecutive too_fast samples; only meaningful while steering.
  always_comb begin
    tf_cnt_d = tf_cnt_q;
    tf_trip  = 1'b0;
    if (state_q != STEER) begin
      tf_cnt_d = 2'd0;
    end else if (bus.vld) begin
      if (bus.too_fast) begin
        tf_trip  = (tf_cnt_q == 2'd3);
        tf_cnt_d = tf_cnt_q + 2'd1;
      end else begin
        tf_cnt_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tf_cnt_q <= 2'd0;
    else        tf_cnt_q <= tf_cnt_d;
  end
`else
  logic unused_fault_in;
  assign unused_fault_in = bus.vld ^ bus.too_fast;
  assign tf_trip         = 1'b0;
`endif

  // pwr_req low overrides everything; SETTLE exit beats a simultaneous timer full.
  always_comb begin
    state_d = state_q;
    if (!bus.pwr_req) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF:     state_d = IDLE;
        IDLE:    if (rider_on_q && balanced) state_d = SETTLE;
        SETTLE:  if (!rider_on_q || !balanced) state_d = IDLE;
                 else if (tmr_full)            state_d = STEER;
        STEER:   if (tf_trip)                  state_d = FAULT;
                 else if (!rider_on_q || step_off) state_d = IDLE;
        FAULT:   state_d = FAULT;
        default: state_d = OFF;
      endcase
    end
  end

  // Outputs are registered from the next state so they move with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OFF;
      lft_q       <= 12'h000;
      rght_q      <= 12'h000;
      rider_on_q  <= 1'b0;
      pwr_up_q    <= 1'b0;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rider_on_q <= rider_on_d;
      if (bus.ld_vld) begin
        lft_q  <= bus.lft_ld;
        rght_q <= bus.rght_ld;
      end
      pwr_up_q    <= (state_d != OFF);
      en_steer_q  <= (state_d == STEER);
      rider_off_q <= (state_d == OFF) || !rider_on_d;
      fault_q     <= (state_d == FAULT);
    end
  end

  assign bus.pwr_up    = pwr_up_q;
  assign bus.en_steer  = en_steer_q;
  assign bus.rider_off = rider_off_q;
  assign bus.fault     = fault_q;

endmodule
